// File: rtl/dds_mod_sequencer.sv
// -----------------------------------------------------------------------------
// dds_mod_sequencer
//
// Purpose:
//   Drives the DDS control port. Replays a signed modulation table at a
//   programmable hold rate. Produces a frequency control word (FM) and/or an
//   amplitude control word (AM) from the current table sample.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   en           clock enable; low freezes sequencing and outputs while running
//   start        pulse: (re)start playback at index 0
//   stop         pulse: return to IDLE (wins over start)
//   mode         0 none, 1 FM, 2 AM, 3 FM+AM
//   base_freq    signed carrier frequency word
//   base_ampl    signed carrier amplitude
//   fm_shift     FM deviation: sample >>> fm_shift
//   hold_cycles  clk cycles per table sample (0 treated as 1)
//   last_addr    last table index played before wrap
//   tbl_we       table write strobe
//   tbl_addr     table write address
//   tbl_data     table write data, signed
//   freq_cntrl   to DDS FreqCntrl
//   ampl_cntrl   to DDS AmplCntrlA
//   sample_idx   current table index
//   busy         high while in RUN
//   wrap         one-cycle pulse when the index wraps last_addr -> 0
// -----------------------------------------------------------------------------
module dds_mod_sequencer #(
  parameter int MOD_ADDR_W = 8,
  parameter int SAMPLE_W   = 16,
  parameter int FREQ_W     = 32,
  parameter int HOLD_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  input  logic signed [FREQ_W-1:0]     base_freq,
  input  logic signed [SAMPLE_W-1:0]   base_ampl,
  input  logic [3:0]                   fm_shift,
  input  logic [HOLD_W-1:0]            hold_cycles,
  input  logic [MOD_ADDR_W-1:0]        last_addr,
  input  logic                         tbl_we,
  input  logic [MOD_ADDR_W-1:0]        tbl_addr,
  input  logic signed [SAMPLE_W-1:0]   tbl_data,
  output logic signed [FREQ_W-1:0]     freq_cntrl,
  output logic signed [SAMPLE_W-1:0]   ampl_cntrl,
  output logic [MOD_ADDR_W-1:0]        sample_idx,
  output logic                         busy,
  output logic                         wrap
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int TBL_DEPTH = 2 ** MOD_ADDR_W;

  logic [0:0]                  state_q, state_d;
  logic [HOLD_W-1:0]           cnt_q, cnt_d;
  logic [MOD_ADDR_W-1:0]       idx_q, idx_d;
  logic                        wrap_q, wrap_d;
  logic signed [FREQ_W-1:0]    freq_q, freq_d;
  logic signed [SAMPLE_W-1:0]  ampl_q, ampl_d;

  logic signed [SAMPLE_W-1:0]  mem [TBL_DEPTH];
  logic signed [SAMPLE_W-1:0]  rd_q;

  logic [HOLD_W-1:0]           hold_last;
  logic signed [SAMPLE_W-1:0]  fm_shifted;
  logic signed [FREQ_W-1:0]    fm_term;
  logic signed [FREQ_W-1:0]    fm_value;
  logic signed [2*SAMPLE_W-1:0] am_a, am_b, am_prod, am_shift;
  logic                        am_ovf;
  logic signed [SAMPLE_W-1:0]  am_value;

  // Table RAM. The read register samples the old contents when a write hits
  // the address being read, because both use non-blocking updates on the
  // same edge. The table is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      mem[tbl_addr] <= tbl_data;
    end
    rd_q <= mem[idx_q];
  end

  // Terminal count of the hold counter; a hold of 0 behaves like a hold of 1.
  assign hold_last = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);

  // Playback control. Stop beats start, and both act even with en low.
  // The >= compare keeps the counter from running the full HOLD_W range
  // when hold_cycles is lowered below the current count on the fly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == RUN && en) begin
      if (cnt_q >= hold_last) begin
        cnt_d = '0;
        if (idx_q == last_addr) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          // A last_addr below idx lets this overflow to 0 with no wrap pulse.
          idx_d = idx_q + MOD_ADDR_W'(1);
        end
      end else begin
        cnt_d = cnt_q + HOLD_W'(1);
      end
    end
  end

  // Modulation arithmetic on the registered table sample.
  // AM keeps the full signed product; only -max * -max can exceed the
  // positive range after the shift, so only the positive side saturates.
  always_comb begin
    fm_shifted = rd_q >>> fm_shift;
    fm_term    = {{(FREQ_W-SAMPLE_W){fm_shifted[SAMPLE_W-1]}}, fm_shifted};
    fm_value   = base_freq + fm_term;

    am_a     = {{SAMPLE_W{base_ampl[SAMPLE_W-1]}}, base_ampl};
    am_b     = {{SAMPLE_W{rd_q[SAMPLE_W-1]}}, rd_q};
    am_prod  = am_a * am_b;
    am_shift = am_prod >>> (SAMPLE_W-1);
    am_ovf   = ~am_shift[2*SAMPLE_W-1] & (|am_shift[2*SAMPLE_W-2:SAMPLE_W-1]);
    am_value = am_ovf ? {1'b0, {(SAMPLE_W-1){1'b1}}} : am_shift[SAMPLE_W-1:0];
  end

  // Output selection. Stop is folded in so the outputs fall back to the base
  // values on the very next cycle instead of one cycle after IDLE is reached.
  always_comb begin
    freq_d = freq_q;
    ampl_d = ampl_q;
    if (state_q == IDLE || stop) begin
      freq_d = base_freq;
      ampl_d = base_ampl;
    end else if (en) begin
      freq_d = mode[0] ? fm_value : base_freq;
      ampl_d = mode[1] ? am_value : base_ampl;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      freq_q  <= '0;
      ampl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      freq_q  <= freq_d;
      ampl_q  <= ampl_d;
    end
  end

  assign freq_cntrl = freq_q;
  assign ampl_cntrl = ampl_q;
  assign sample_idx = idx_q;
  assign busy       = (state_q == RUN);
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dds_mod_sequencer
//
// Purpose:
//   Directed self-checking bench for dds_mod_sequencer: reset, FM and AM
//   arithmetic with saturation, index wrap, enable freeze, start/stop
//   priority, read-first table behaviour and table retention over reset.
// -----------------------------------------------------------------------------
module tb_dds_mod_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic signed [31:0] base_freq;
  logic signed [15:0] base_ampl;
  logic [3:0]         fm_shift;
  logic [15:0]        hold_cycles;
  logic [7:0]         last_addr;
  logic               tbl_we;
  logic [7:0]         tbl_addr;
  logic signed [15:0] tbl_data;
  logic signed [31:0] freq_cntrl;
  logic signed [15:0] ampl_cntrl;
  logic [7:0]         sample_idx;
  logic               busy;
  logic               wrap;

  int checks   = 0;
  int failures = 0;

  dds_mod_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .base_freq   (base_freq),
    .base_ampl   (base_ampl),
    .fm_shift    (fm_shift),
    .hold_cycles (hold_cycles),
    .last_addr   (last_addr),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .freq_cntrl  (freq_cntrl),
    .ampl_cntrl  (ampl_cntrl),
    .sample_idx  (sample_idx),
    .busy        (busy),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic writeTable(input logic [7:0] a, input logic signed [15:0] d);
    tbl_we   = 1'b1;
    tbl_addr = a;
    tbl_data = d;
    applyStimulus(1);
    tbl_we   = 1'b0;
  endtask

  initial begin
    int wrapIdx [5];
    wrapIdx = '{1, 2, 3, 0, 1};

    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    base_freq = 0; base_ampl = 0; fm_shift = 4'd0; hold_cycles = 16'd0;
    last_addr = 8'd0; tbl_we = 1'b0; tbl_addr = 8'd0; tbl_data = 16'sd0;
    applyStimulus(2);

    // Power-on reset values
    checkOutput("rst_freq", freq_cntrl, 0);
    checkOutput("rst_ampl", $signed(ampl_cntrl), 0);
    checkOutput("rst_idx", sample_idx, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wrap", wrap, 0);

    rst = 1'b0; en = 1'b1; mode = 2'd1; base_freq = 30000; base_ampl = 16'h7FFF;
    fm_shift = 4'd2; hold_cycles = 16'd4; last_addr = 8'd1;
    writeTable(8'd0, 16'h4000);
    writeTable(8'd1, 16'h8000);
    writeTable(8'd2, 16'h1000);
    writeTable(8'd3, 16'hC000);
    checkOutput("idle_freq", freq_cntrl, 30000);
    checkOutput("idle_ampl", $signed(ampl_cntrl), 32767);

    // FM playback with hold 4 over entries 0 and 1
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("fm_busy", busy, 1);
    checkOutput("fm_idx0", sample_idx, 0);
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1);
      if (c >= 2 && c <= 5) checkOutput("fm_val0", freq_cntrl, 34096);
      if (c >= 6) checkOutput("fm_val1", freq_cntrl, 21808);
      if (c == 4) checkOutput("fm_idx1", sample_idx, 1);
      if (c == 8) begin
        checkOutput("fm_wrap_idx", sample_idx, 0);
        checkOutput("fm_wrap", wrap, 1);
      end
      if (c == 9) checkOutput("fm_wrap_end", wrap, 0);
    end

    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_freq", freq_cntrl, 30000);

    // AM with last_addr 0: entry 0 replayed, wrap on every advance
    mode = 2'd2; last_addr = 8'd0; hold_cycles = 16'd1;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(1);
    checkOutput("am_idx", sample_idx, 0);
    checkOutput("am_wrap", wrap, 1);
    applyStimulus(1);
    checkOutput("am_val", $signed(ampl_cntrl), 16383);
    checkOutput("am_freq_base", freq_cntrl, 30000);

    // New base amplitude plus a write to the address being read
    base_ampl = 16'h8000;
    tbl_we = 1'b1; tbl_addr = 8'd0; tbl_data = 16'h8000;
    applyStimulus(1);
    tbl_we = 1'b0;
    checkOutput("am_newbase", $signed(ampl_cntrl), -16384);
    applyStimulus(1);
    checkOutput("rd_first_old", $signed(ampl_cntrl), -16384);
    applyStimulus(1);
    checkOutput("am_sat", $signed(ampl_cntrl), 32767);

    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    checkOutput("stop_ampl", $signed(ampl_cntrl), -32768);

    // Wrap sequence with hold 0 and last_addr 3
    mode = 2'd1; fm_shift = 4'd0; base_freq = 100; hold_cycles = 16'd0;
    last_addr = 8'd3;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("wr_idx0", sample_idx, 0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1);
      checkOutput("wr_idx", sample_idx, wrapIdx[c-1]);
      checkOutput("wr_pulse", wrap, (c == 4) ? 1 : 0);
      if (c == 4) checkOutput("wr_freq2", freq_cntrl, 4196);
      if (c == 5) checkOutput("wr_freq3", freq_cntrl, -16284);
    end

    // Enable low for 5 clocks freezes everything
    en = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1);
      checkOutput("frz_idx", sample_idx, 1);
      checkOutput("frz_wrap", wrap, 0);
      checkOutput("frz_freq", freq_cntrl, -16284);
    end
    en = 1'b1;
    applyStimulus(1);
    checkOutput("unfrz_idx", sample_idx, 2);
    checkOutput("unfrz_freq", freq_cntrl, -32668);

    // Start and stop together: stop wins
    base_freq = 555;
    start = 1'b1; stop = 1'b1;
    applyStimulus(1);
    start = 1'b0; stop = 1'b0;
    checkOutput("ss_busy", busy, 0);
    checkOutput("ss_freq", freq_cntrl, 555);
    checkOutput("ss_ampl", $signed(ampl_cntrl), -32768);

    // Reset in the middle of a run
    mode = 2'd3; base_freq = 1234;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(3);
    checkOutput("pre_rst_busy", busy, 1);
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("mrst_freq", freq_cntrl, 0);
    checkOutput("mrst_ampl", $signed(ampl_cntrl), 0);
    checkOutput("mrst_idx", sample_idx, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_wrap", wrap, 0);

    // Table survives reset: entry 0 still holds the value written mid-run
    mode = 2'd1; fm_shift = 4'd0; base_freq = 0; hold_cycles = 16'd100;
    last_addr = 8'd3;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(2);
    checkOutput("tbl_retained", freq_cntrl, -32768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
